// File: rtl/timer_ctrl_if.sv
// Register-write bus and status lines between the core and timer_ctrl.
// The core side drives writes and irq_ack; the timer side returns count/irq/busy.
interface timer_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             irq_ack;
    logic [WIDTH-1:0] cnt;
    logic             irq;
    logic             busy;

    modport master (
        output wr_en, wr_addr, wr_data, irq_ack,
        input  cnt, irq, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, irq_ack,
        output cnt, irq, busy
    );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable timer: WIDTH-bit up-counter advanced by a prescaled tick,
// compare match with sticky level interrupt, one-shot or periodic operation.
// Register map: 0=CTRL (start/stop/periodic/clear), 1=CMP, 2=PSC, 3=reserved.
// PSC_W must not exceed WIDTH (PSC is taken from the low bits of wr_data).
module timer_ctrl #(
    parameter int WIDTH = 32,
    parameter int PSC_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   cnt_q, cnt_n;
    logic [PSC_W-1:0]   pre_q, pre_n;
    logic               irq_q, irq_n;

    logic [WIDTH-1:0]   cmp_q;
    logic [PSC_W-1:0]   psc_q;
    logic               periodic_q;

    logic               ctrl_wr;
    logic               cmd_start;
    logic               cmd_stop;
    logic               cmd_clear;
    logic               tick;
    logic               match;

    // Decode self-clearing command bits from a CTRL write
    always_comb begin
        ctrl_wr   = bus.wr_en && (bus.wr_addr == 2'd0);
        cmd_start = ctrl_wr && bus.wr_data[0];
        cmd_stop  = ctrl_wr && bus.wr_data[1];
        cmd_clear = ctrl_wr && bus.wr_data[3];
        tick      = (state_q == RUN) && (pre_q == psc_q);
        match     = tick && (cnt_q == cmp_q);
    end

    // Configuration registers: compare value, prescaler reload, periodic flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q      <= '1;
            psc_q      <= '0;
            periodic_q <= 1'b0;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                2'd0:    periodic_q <= bus.wr_data[2];
                2'd1:    cmp_q      <= bus.wr_data;
                2'd2:    psc_q      <= bus.wr_data[PSC_W-1:0];
                default: ;
            endcase
        end
    end

    // Next-state, counter, prescaler and interrupt logic
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pre_n   = pre_q;
        irq_n   = irq_q;

        if (bus.irq_ack) begin
            irq_n = 1'b0;
        end

        case (state_q)
            IDLE: begin
                pre_n = '0;
                if (cmd_start && !cmd_stop) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (cmd_stop) begin
                    // stop beats start in the same write; count is frozen
                    state_n = IDLE;
                    pre_n   = '0;
                end else if (!cmd_clear) begin
                    if (tick) begin
                        pre_n = '0;
                        if (match) begin
                            // a new match beats a simultaneous irq_ack
                            irq_n = 1'b1;
                            if (periodic_q) begin
                                cnt_n = '0;
                            end else begin
                                state_n = DONE;
                            end
                        end else begin
                            cnt_n = cnt_q + WIDTH'(1);
                        end
                    end else begin
                        pre_n = pre_q + PSC_W'(1);
                    end
                end
            end
            DONE: begin
                pre_n = '0;
                if (cmd_start && !cmd_stop) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else if (bus.irq_ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                pre_n   = '0;
            end
        endcase

        // clear resets count and prescaler in any state without moving the FSM
        if (cmd_clear) begin
            cnt_n = '0;
            pre_n = '0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pre_q   <= pre_n;
            irq_q   <= irq_n;
        end
    end

    // Output drive
    always_comb begin
        bus.cnt  = cnt_q;
        bus.irq  = irq_q;
        bus.busy = (state_q == RUN);
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a 4-bit counter so wrap cases are short.
module tb_timer_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    timer_ctrl_if #(.WIDTH(W)) bus ();

    timer_ctrl #(
        .WIDTH (W),
        .PSC_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        step(1);
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.irq_ack = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_cnt", bus.cnt, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_busy", bus.busy, 0);

        // reserved address: start bit must be ignored
        wr(2'd3, 4'h1);
        check("rsv_busy", bus.busy, 0);

        // 1: periodic, PSC=0, CMP=3 -> 0,1,2,3,0,...
        wr(2'd2, 4'd0);
        wr(2'd1, 4'd3);
        wr(2'd0, 4'b0101);
        check("t1_busy", bus.busy, 1);
        check("t1_cnt0", bus.cnt, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check($sformatf("t1_cnt%0d", i), bus.cnt, i % 4);
            check($sformatf("t1_irq%0d", i), bus.irq, (i >= 4) ? 1 : 0);
        end
        wr(2'd0, 4'b0010);
        check("t1_stop_busy", bus.busy, 0);
        check("t1_stop_cnt", bus.cnt, 0);
        ack();
        check("t1_ack_irq", bus.irq, 0);

        // 2: one-shot, PSC=2, CMP=1
        wr(2'd2, 4'd2);
        wr(2'd1, 4'd1);
        wr(2'd0, 4'b0001);
        check("t2_busy", bus.busy, 1);
        step(2);
        check("t2_cnt_k2", bus.cnt, 0);
        step(1);
        check("t2_cnt_k3", bus.cnt, 1);
        step(2);
        check("t2_irq_k5", bus.irq, 0);
        check("t2_busy_k5", bus.busy, 1);
        step(1);
        check("t2_irq_k6", bus.irq, 1);
        check("t2_busy_k6", bus.busy, 0);
        check("t2_cnt_k6", bus.cnt, 1);
        step(2);
        check("t2_hold", bus.cnt, 1);
        ack();
        check("t2_ack_irq", bus.irq, 0);
        check("t2_ack_busy", bus.busy, 0);

        // 3: lower CMP below count while running -> wrap before match
        wr(2'd2, 4'd0);
        wr(2'd1, 4'd5);
        wr(2'd0, 4'b0101);
        step(3);
        check("t3_cnt3", bus.cnt, 3);
        wr(2'd1, 4'd2);
        check("t3_cnt4", bus.cnt, 4);
        for (int j = 1; j <= 14; j++) begin
            step(1);
            check($sformatf("t3_cnt_j%0d", j), bus.cnt, (4 + j) % 16);
            check($sformatf("t3_irq_j%0d", j), bus.irq, 0);
        end
        step(1);
        check("t3_match_cnt", bus.cnt, 0);
        check("t3_match_irq", bus.irq, 1);
        wr(2'd0, 4'b0010);
        ack();
        check("t3_ack_irq", bus.irq, 0);

        // 4: CMP=0 periodic, ack colliding with a match keeps irq
        wr(2'd1, 4'd0);
        wr(2'd0, 4'b0101);
        step(1);
        check("t4_irq_set", bus.irq, 1);
        ack();
        check("t4_ack_in_match", bus.irq, 1);
        wr(2'd0, 4'b0010);
        check("t4_stopped", bus.busy, 0);
        ack();
        check("t4_ack_idle", bus.irq, 0);

        // 5: start|stop from IDLE; clear while running
        wr(2'd0, 4'b0011);
        check("t5_ss_busy", bus.busy, 0);
        check("t5_ss_cnt", bus.cnt, 0);
        wr(2'd1, 4'd15);
        wr(2'd0, 4'b0001);
        step(7);
        check("t5_cnt7", bus.cnt, 7);
        wr(2'd0, 4'b1000);
        check("t5_clr_cnt", bus.cnt, 0);
        check("t5_clr_busy", bus.busy, 1);
        step(1);
        check("t5_after_clr", bus.cnt, 1);

        // 6: reset mid-count with irq set, concurrent write ignored
        wr(2'd0, 4'b0010);
        wr(2'd1, 4'd2);
        wr(2'd0, 4'b0101);
        step(3);
        check("t6_irq_pre", bus.irq, 1);
        wr(2'd1, 4'd15);
        step(8);
        check("t6_cnt9", bus.cnt, 9);
        check("t6_busy_pre", bus.busy, 1);
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 4'd1;
        step(1);
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        check("t6_rst_cnt", bus.cnt, 0);
        check("t6_rst_irq", bus.irq, 0);
        check("t6_rst_busy", bus.busy, 0);
        // CMP back to all-ones and PSC back to 0: one-shot counts every clock to 15
        wr(2'd0, 4'b0001);
        step(15);
        check("t6_cnt15", bus.cnt, 15);
        check("t6_irq15", bus.irq, 0);
        step(1);
        check("t6_match_irq", bus.irq, 1);
        check("t6_match_busy", bus.busy, 0);
        check("t6_match_cnt", bus.cnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
